mux1hot_rr_arbiter3: RTL and testbench
======================================

Name: mux1hot_rr_arbiter3

Overview:
- Round-robin, packet-locking arbiter that shares one WIDTH-bit output stream among three valid/ready requesters.
- Internally it generates a one-hot 3-bit select and steers data through a one-hot 3:1 mux.
- It sits in front of any single-consumer datapath fed by three sources.
- It holds the grant for a whole packet (until last, or until a beat limit is reached), then rotates priority.

Parameters:
- WIDTH, 8: data width of each requester and of the output.
- MAX_BEATS, 16: forced-release beat limit per grant. 0 disables the limit. Legal range 0..255.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in0_valid, in1_valid, in2_valid  input  1 each  requester beat valid
- in0_data, in1_data, in2_data  input  WIDTH each  requester beat data
- in0_last, in1_last, in2_last  input  1 each  final beat of requester packet
- in0_ready, in1_ready, in2_ready  output  1 each  beat accepted from requester
- out_valid  output  1  output beat valid
- out_data  output  WIDTH  output beat data
- out_last  output  1  output final beat (real or forced)
- out_ready  input  1  downstream accepts beat
- grant  output  3  registered one-hot owner; 000 when idle
- busy  output  1  high in LOCKED state

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, grant=000, prio pointer=0 (in0 highest), beat counter=0.
  - All in*_ready=0, out_valid=0, out_last=0, out_data=0, busy=0.
  - Reset mid-packet aborts the packet silently. No beat is transferred in the reset cycle. Outputs are derived from registered state, so they are in reset values from the cycle after the reset edge.
- States:
  - IDLE: no grant.
    - If any in*_valid=1, the winner is the first valid requester searching prio, prio+1, prio+2 (mod 3).
    - Next cycle: state=LOCKED, grant=onehot(winner), counter=0.
    - If none valid, stay IDLE.
    - No beat transfers in IDLE (1-cycle arbitration bubble).
  - LOCKED, owner g:
    - out_valid = in{g}_valid and out_data = in{g}_data, both combinational through the one-hot mux.
    - in{g}_ready = out_ready. Non-owners have ready=0.
    - Handshake = out_valid & out_ready.
- Forced last: out_last = in{g}_last | (MAX_BEATS!=0 & counter==MAX_BEATS-1).
- Handshake with out_last=1:
  - Next cycle: state=IDLE, grant=000, prio=(g+1) mod 3, counter=0.
  - No back-to-back grant without the idle cycle.
- Handshake without out_last: counter increments. It saturates logically because forced last fires at MAX_BEATS-1.
- Owner dropping valid mid-packet: lock is held and out_valid=0. Other requesters wait indefinitely (no timeout on stalls).
- out_ready=0: nothing changes; counter holds.
- Output data when not LOCKED or owner invalid: out_data=0. Never X.
- Grant encoding: exactly one bit set in LOCKED, zero bits in IDLE. Any other value is unreachable.
- Non-owner valid/data/last changes while locked: ignored, no effect on state.
- MAX_BEATS=1: every beat is a packet; grants rotate every 2 cycles under full load.

Test Plan:
- Reset then single request:
  - Stimulus: rst for 2 cycles, then in1_valid=1, data=0x5A, last=1, out_ready=1.
  - Response: cycle after request grant=010, busy=1, out_valid=1, out_data=0x5A, out_last=1, in1_ready=1. Next cycle grant=000.
- Round-robin fairness:
  - Stimulus: all three always valid with 1-beat packets, out_ready=1.
  - Response: grant sequence 001,000,010,000,100,000,001 repeating. Each requester gets 1 beat per 6 cycles.
- Packet lock:
  - Stimulus: in0 sends 4-beat packet (last on beat 4) while in2 valid throughout.
  - Response: grant=001 for all 4 beats, in2_ready=0 throughout. Then IDLE, then grant=100.
- Backpressure and owner gap:
  - Stimulus: during in1 packet, out_ready=0 for 3 cycles, then in1_valid=0 for 2 cycles.
  - Response: out_data holds, no counter change, grant stays 010, out_valid mirrors in1_valid.
- Forced release:
  - Stimulus: MAX_BEATS=4; in2 streams 10 beats with last=0, in0 valid.
  - Response: out_last=1 on beat 4. Grant moves 100→000→001 after beat 4. in2 is regranted only after in0 is served.
- Reset mid-packet:
  - Stimulus: assert rst on beat 2 of an in0 packet.
  - Response: next cycle grant=000, all ready=0, out_data=0. After release with in0 and in1 both valid, in0 wins (prio reset to 0).

Source files
------------

// File: rtl/mux1hot_rr_arbiter3.sv
// Three-way round-robin arbiter that locks the grant for a whole packet (or MAX_BEATS beats).
// Grant/state are registered; the data path is a combinational one-hot 3:1 mux.
module mux1hot_rr_arbiter3 #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_last,
  output logic             in2_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [2:0]       grant,
  output logic             busy
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  localparam bit         LIMIT_EN = (MAX_BEATS != 0);
  localparam logic [7:0] LAST_CNT = (MAX_BEATS == 0) ? 8'd0 : 8'(MAX_BEATS - 1);

  state_t     state_q;
  logic [2:0] grant_q;
  logic [1:0] prio_q;
  logic [7:0] cnt_q;

  logic [2:0]       in_valid;
  logic [2:0]       in_last;
  logic [WIDTH-1:0] in_data [3];

  assign in_valid   = {in2_valid, in1_valid, in0_valid};
  assign in_last    = {in2_last, in1_last, in0_last};
  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;
  assign in_data[2] = in2_data;

  // Rotate requests so the priority holder sits at bit 0, pick first, rotate back.
  function automatic logic [2:0] pick(input logic [2:0] v, input logic [1:0] p);
    logic [2:0] r;
    logic [2:0] o;
    case (p)
      2'd1:    r = {v[0], v[2], v[1]};
      2'd2:    r = {v[1], v[0], v[2]};
      default: r = v;
    endcase
    if (r[0])      o = 3'b001;
    else if (r[1]) o = 3'b010;
    else if (r[2]) o = 3'b100;
    else           o = 3'b000;
    case (p)
      2'd1:    pick = {o[1], o[0], o[2]};
      2'd2:    pick = {o[0], o[2], o[1]};
      default: pick = o;
    endcase
  endfunction

  logic [2:0]       win_oh;
  logic [1:0]       prio_d;
  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             forced_last;
  logic             hs;

  assign win_oh = pick(in_valid, prio_q);

  always_comb begin
    prio_d = 2'd0;
    if (grant_q[0]) prio_d = 2'd1;
    if (grant_q[1]) prio_d = 2'd2;
  end

  // grant_q is zero outside LOCKED, so every term collapses to zero when idle.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < 3; i++) begin
      sel_valid = sel_valid | (grant_q[i] & in_valid[i]);
      sel_last  = sel_last  | (grant_q[i] & in_last[i]);
      sel_data  = sel_data  | ({WIDTH{grant_q[i] & in_valid[i]}} & in_data[i]);
    end
  end

  assign forced_last = LIMIT_EN && (state_q == S_LOCKED) && (cnt_q == LAST_CNT);

  assign out_valid = sel_valid;
  assign out_data  = sel_data;
  assign out_last  = sel_last | forced_last;
  assign in0_ready = grant_q[0] & out_ready;
  assign in1_ready = grant_q[1] & out_ready;
  assign in2_ready = grant_q[2] & out_ready;
  assign hs        = out_valid & out_ready;
  assign grant     = grant_q;
  assign busy      = (state_q == S_LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 3'b000;
      prio_q  <= 2'd0;
      cnt_q   <= 8'd0;
    end else if (state_q == S_IDLE) begin
      if (|win_oh) begin
        state_q <= S_LOCKED;
        grant_q <= win_oh;
        cnt_q   <= 8'd0;
      end
    end else if (hs) begin
      if (out_last) begin
        state_q <= S_IDLE;
        grant_q <= 3'b000;
        prio_q  <= prio_d;
        cnt_q   <= 8'd0;
      end else if (cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mux1hot_rr_arbiter3.sv
// Directed bench: dut_a uses the default beat limit (16), dut_b a limit of 4; both share inputs.
module tb_mux1hot_rr_arbiter3;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in0_valid, in1_valid, in2_valid;
  logic in0_last, in1_last, in2_last;
  logic [W-1:0] in0_data, in1_data, in2_data;
  logic out_ready;

  logic in0_ready_a, in1_ready_a, in2_ready_a, out_valid_a, out_last_a, busy_a;
  logic [W-1:0] out_data_a;
  logic [2:0] grant_a;
  logic in0_ready_b, in1_ready_b, in2_ready_b, out_valid_b, out_last_b, busy_b;
  logic [W-1:0] out_data_b;
  logic [2:0] grant_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux1hot_rr_arbiter3 #(.WIDTH(W), .MAX_BEATS(16)) dut_a (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready_a),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready_a),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_last(in2_last), .in2_ready(in2_ready_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_last(out_last_a), .out_ready(out_ready),
    .grant(grant_a), .busy(busy_a)
  );

  mux1hot_rr_arbiter3 #(.WIDTH(W), .MAX_BEATS(4)) dut_b (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready_b),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready_b),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_last(in2_last), .in2_ready(in2_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b), .out_ready(out_ready),
    .grant(grant_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    in0_valid = 0; in1_valid = 0; in2_valid = 0;
    in0_last  = 0; in1_last  = 0; in2_last  = 0;
    in0_data  = 0; in1_data  = 0; in2_data  = 0;
    out_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    nxt();
    nxt();
    rst = 0;
  endtask

  logic [2:0]   rr_g [7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
  logic [W-1:0] rr_d [7] = '{8'hA0, 8'h00, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA0};

  initial begin
    // Reset state
    do_reset();
    settle();
    check("rst_grant", grant_a, 3'b000);
    check("rst_busy", busy_a, 1'b0);
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_out_last", out_last_a, 1'b0);
    check("rst_out_data", out_data_a, 8'h00);
    check("rst_readys", {in2_ready_a, in1_ready_a, in0_ready_a}, 3'b000);

    // Single request from in1
    in1_valid = 1; in1_data = 8'h5A; in1_last = 1; out_ready = 1;
    nxt(); settle();
    check("single_grant", grant_a, 3'b010);
    check("single_busy", busy_a, 1'b1);
    check("single_out_valid", out_valid_a, 1'b1);
    check("single_out_data", out_data_a, 8'h5A);
    check("single_out_last", out_last_a, 1'b1);
    check("single_in1_ready", in1_ready_a, 1'b1);
    check("single_in0_ready", in0_ready_a, 1'b0);
    nxt();
    in1_valid = 0;
    settle();
    check("single_release", grant_a, 3'b000);
    check("single_idle_valid", out_valid_a, 1'b0);

    // Round-robin fairness with 1-beat packets
    do_reset();
    in0_valid = 1; in1_valid = 1; in2_valid = 1;
    in0_last = 1; in1_last = 1; in2_last = 1;
    in0_data = 8'hA0; in1_data = 8'hA1; in2_data = 8'hA2;
    out_ready = 1;
    for (int i = 0; i < 7; i++) begin
      nxt(); settle();
      check($sformatf("rr_grant_%0d", i), grant_a, rr_g[i]);
      check($sformatf("rr_data_%0d", i), out_data_a, rr_d[i]);
    end

    // Packet lock: in0 4-beat packet, in2 waiting
    do_reset();
    in0_valid = 1; in2_valid = 1; in2_last = 1; in2_data = 8'hE2; out_ready = 1;
    nxt();
    for (int b = 0; b < 4; b++) begin
      in0_data = 8'h10 + 8'(b);
      in0_last = (b == 3);
      settle();
      check($sformatf("lock_grant_%0d", b), grant_a, 3'b001);
      check($sformatf("lock_in2_ready_%0d", b), in2_ready_a, 1'b0);
      check($sformatf("lock_data_%0d", b), out_data_a, 8'h10 + 8'(b));
      check($sformatf("lock_last_%0d", b), out_last_a, (b == 3));
      nxt();
    end
    settle();
    check("lock_idle", grant_a, 3'b000);
    nxt(); settle();
    check("lock_next_in2", grant_a, 3'b100);

    // Backpressure and owner gap on in1; dut_b's limit exposes the beat count
    do_reset();
    in1_valid = 1; in1_data = 8'h33; out_ready = 1;
    nxt(); settle();
    check("bp_first_data", out_data_a, 8'h33);
    check("bp_first_last_b", out_last_b, 1'b0);
    nxt();
    out_ready = 0; in1_data = 8'h44;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("bp_stall_grant_%0d", i), grant_a, 3'b010);
      check($sformatf("bp_stall_data_%0d", i), out_data_a, 8'h44);
      check($sformatf("bp_stall_ready_%0d", i), in1_ready_a, 1'b0);
      check($sformatf("bp_stall_valid_%0d", i), out_valid_a, 1'b1);
      nxt();
    end
    out_ready = 1; in1_valid = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("gap_valid_%0d", i), out_valid_a, 1'b0);
      check($sformatf("gap_data_%0d", i), out_data_a, 8'h00);
      check($sformatf("gap_grant_%0d", i), grant_a, 3'b010);
      nxt();
    end
    in1_valid = 1;
    for (int b = 0; b < 3; b++) begin
      in1_data = 8'h55 + 8'(b);
      settle();
      check($sformatf("bp_resume_data_%0d", b), out_data_a, 8'h55 + 8'(b));
      check($sformatf("bp_resume_last_b_%0d", b), out_last_b, (b == 2));
      nxt();
    end
    settle();
    check("bp_b_released", grant_b, 3'b000);
    check("bp_a_held", grant_a, 3'b010);

    // Forced release on dut_b (limit 4): in2 streams with last=0, in0 waiting
    do_reset();
    in2_valid = 1; in2_data = 8'h20; out_ready = 1;
    nxt();
    in0_valid = 1; in0_last = 1; in0_data = 8'h0C;
    for (int b = 0; b < 4; b++) begin
      in2_data = 8'h20 + 8'(b);
      settle();
      check($sformatf("force_grant_%0d", b), grant_b, 3'b100);
      check($sformatf("force_last_%0d", b), out_last_b, (b == 3));
      check($sformatf("force_in0_ready_%0d", b), in0_ready_b, 1'b0);
      check($sformatf("force_data_%0d", b), out_data_b, 8'h20 + 8'(b));
      nxt();
    end
    settle();
    check("force_idle", grant_b, 3'b000);
    nxt(); settle();
    check("force_in0_grant", grant_b, 3'b001);
    check("force_in0_data", out_data_b, 8'h0C);
    check("force_in2_wait", in2_ready_b, 1'b0);
    nxt(); settle();
    check("force_idle2", grant_b, 3'b000);
    nxt(); settle();
    check("force_in2_regrant", grant_b, 3'b100);

    // Reset mid-packet: first move prio to 1, then abort an in0 packet
    do_reset();
    in0_valid = 1; in0_last = 1; in0_data = 8'h11; out_ready = 1;
    nxt(); settle();
    check("mid_pre_grant", grant_a, 3'b001);
    nxt();
    in0_last = 0; in0_data = 8'h77;
    nxt(); settle();
    check("mid_pkt_grant", grant_a, 3'b001);
    nxt(); settle();
    check("mid_beat2_data", out_data_a, 8'h77);
    rst = 1; in1_valid = 1;
    nxt();
    rst = 0;
    settle();
    check("mid_rst_grant", grant_a, 3'b000);
    check("mid_rst_readys", {in2_ready_a, in1_ready_a, in0_ready_a}, 3'b000);
    check("mid_rst_data", out_data_a, 8'h00);
    check("mid_rst_valid", out_valid_a, 1'b0);
    check("mid_rst_busy", busy_a, 1'b0);
    nxt(); settle();
    check("mid_prio_reset", grant_a, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
